// File: rtl/md_unit_param.sv
`timescale 1ns/1ps
// md_unit_param
//   HI/LO multiply-divide unit for the E stage. The op arrives pre-decoded.
//   Long ops (mult/div/madd/msub class) compute their full result at the
//   accept edge. The result waits in a temp register while a counter models
//   the configured latency. {hi,lo} takes the result on the last busy edge.
//
// Parameters
//   WIDTH        operand and HI/LO width (>= 2)
//   MULT_CYCLES  busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (>= 1)
//   DIV_CYCLES   busy cycles for DIV/DIVU (>= 1)
//
// Ports
//   clk, reset       rising-edge clock, async active-high reset
//   op_valid, op     op strobe and code (0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                    5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO)
//   src_a, src_b     rs / rt operands
//   req              exception request; blocks acceptance this cycle
//   hi, lo           architectural HI/LO
//   busy             long op in flight
//   stall            combinational hazard request
//   done             one-cycle pulse after hi/lo take a long-op result
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int W2   = 2 * WIDTH;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [W2-1:0]   temp, res;
    logic            is_long, is_div, accept, last;

    assign busy    = (state == S_RUN);
    assign is_long = (op >= OP_MULT) && (op <= OP_MSUBU);
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign accept  = op_valid & ~req & ~busy;
    assign stall   = busy | (op_valid & is_long & ~req);
    assign last    = busy && (cnt == CW'(1));

    // ---------------- multiply ----------------
    // Sign/zero extending to 2*WIDTH first makes the low 2*WIDTH bits of a
    // plain multiply equal the exact signed/unsigned product.
    logic [W2-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, acc;

    assign a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign a_zx   = {{WIDTH{1'b0}}, src_a};
    assign b_zx   = {{WIDTH{1'b0}}, src_b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign acc    = {hi, lo};

    // ---------------- divide ----------------
    // Signed divide runs on magnitudes. For MIN / -1 the magnitude quotient
    // is 2^(WIDTH-1), which truncates back to MIN with a zero remainder.
    // That is the required overflow result, so no special case is needed.
    // Divisors are forced nonzero before the divide so nothing can go X.
    // The zero-divisor result is then substituted.
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag, bs_safe, bu_safe;
    logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign a_neg   = src_a[WIDTH-1];
    assign b_neg   = src_b[WIDTH-1];
    assign b_zero  = (src_b == '0);
    assign a_mag   = a_neg ? -src_a : src_a;
    assign b_mag   = b_neg ? -src_b : src_b;
    assign bs_safe = b_zero ? WIDTH'(1) : b_mag;
    assign bu_safe = b_zero ? WIDTH'(1) : src_b;
    assign q_mag   = a_mag / bs_safe;
    assign r_mag   = a_mag % bs_safe;
    assign q_s     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_s     = a_neg ? -r_mag : r_mag;
    assign q_u     = src_a / bu_safe;
    assign r_u     = src_a % bu_safe;

    // {hi, lo} layout: remainder in the upper half, quotient in the lower.
    always_comb begin
        res = '0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = b_zero ? {src_a, {WIDTH{1'b1}}} : {r_s, q_s};
            OP_DIVU:  res = b_zero ? {src_a, {WIDTH{1'b1}}} : {r_u, q_u};
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
            default:  res = '0;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept && is_long) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    // An accept can only happen while idle, and `last` only while running.
    // So an MTHI/MTLO write never collides with a result write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            temp <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            done <= last;
            if (accept && is_long)        temp <= res;
            if (accept && op == OP_MTHI)  hi   <= src_a;
            if (accept && op == OP_MTLO)  lo   <= src_a;
            if (last)                     {hi, lo} <= temp;
        end
    end

endmodule

// File: tb/tb_md_unit_param.sv
`timescale 1ns/1ps
module tb_md_unit_param;

    logic        clk = 1'b0, reset = 1'b1;
    logic        op_valid = 1'b0, req = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0, src_b = '0, hi, lo;
    logic        busy, stall, done;

    logic        op_valid16 = 1'b0, req16 = 1'b0;
    logic [3:0]  op16 = 4'd0;
    logic [15:0] src_a16 = '0, src_b16 = '0, hi16, lo16;
    logic        busy16, stall16, done16;

    int          total = 0, bad = 0, done_cnt = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    md_unit_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .req(req),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done));

    md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
        .clk(clk), .reset(reset), .op_valid(op_valid16), .op(op16),
        .src_a(src_a16), .src_b(src_b16), .req(req16),
        .hi(hi16), .lo(lo16), .busy(busy16), .stall(stall16), .done(done16));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("result", {hi, lo}, sb.pop_front());
        end
    end

    task automatic short_op(input logic [3:0] o, input logic [31:0] a);
        @(negedge clk);
        op_valid = 1'b1; op = o; src_a = a; req = 1'b0;
        #1 chk("stall_short", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; op = 4'd0;
    endtask

    task automatic long_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int n);
        int cyc;
        int d0;
        d0 = done_cnt;
        sb.push_back(exp);
        @(negedge clk);
        op_valid = 1'b1; op = o; src_a = a; src_b = b; req = 1'b0;
        #1 chk({tag, "_stall"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op = 4'd0;
        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_busylen"}, 64'(cyc), 64'(n));
        @(negedge clk); #1;
        chk({tag, "_done"}, 64'(done_cnt), 64'(d0 + 1));
        @(posedge clk); #1;
        chk({tag, "_donepulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b, sv_hi, sv_lo;
        logic [63:0] exp;
        longint      sa, sb_l;
        int          si, sd;
        int          cyc, d0;

        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        long_op("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5);
        long_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 5);

        short_op(4'd9, 32'd1);
        chk("mthi", 64'(hi), 64'd1);
        short_op(4'd10, 32'd2);
        chk("mtlo", 64'(lo), 64'd2);
        long_op("madd",  4'd5, 32'd3, 32'd4,  64'h00000001_0000000E, 5);
        long_op("msubu", 4'd8, 32'd1, 32'd15, 64'h00000000_FFFFFFFF, 5);

        long_op("div",    4'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10);
        long_op("divu0",  4'd4, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, 10);
        long_op("div0",   4'd3, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 10);
        long_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10);

        // DIV with req: dropped entirely.
        sv_hi = hi; sv_lo = lo; d0 = done_cnt;
        @(negedge clk);
        op_valid = 1'b1; op = 4'd3; src_a = 32'd10; src_b = 32'd3; req = 1'b1;
        #1 chk("req_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; op = 4'd0; req = 1'b0;
        chk("req_busy", 64'(busy), 64'd0);
        repeat (12) @(posedge clk); #1;
        chk("req_hilo", {hi, lo}, {sv_hi, sv_lo});
        chk("req_nodone", 64'(done_cnt), 64'(d0));

        // MTLO while busy is ignored; req while busy does not abort.
        sb.push_back(64'd30);
        @(negedge clk);
        op_valid = 1'b1; op = 4'd1; src_a = 32'd5; src_b = 32'd6;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 4'd0;
        sv_lo = lo;
        @(negedge clk);
        op_valid = 1'b1; op = 4'd10; src_a = 32'hDEADBEEF; req = 1'b1;
        #1 chk("busy_mtlo_stall", 64'(stall), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op = 4'd0; req = 1'b0;
        chk("busy_mtlo_lo", 64'(lo), 64'(sv_lo));
        chk("busy_req_busy", 64'(busy), 64'd1);
        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_mtlo_len", 64'(cyc), 64'd4);
        @(negedge clk); #1;
        chk("busy_mtlo_final", {hi, lo}, 64'd30);

        // Randomised mult/div against a behavioural model.
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            case (i % 4)
                0: begin
                    b = $urandom;
                    sa = longint'($signed(a)); sb_l = longint'($signed(b));
                    long_op("rmult", 4'd1, a, b, 64'(sa * sb_l), 5);
                end
                1: begin
                    b = $urandom;
                    exp = {32'd0, a} * {32'd0, b};
                    long_op("rmultu", 4'd2, a, b, exp, 5);
                end
                2: begin
                    b = ($urandom % 32'd65536) + 32'd1;
                    long_op("rdivu", 4'd4, a, b, {a % b, a / b}, 10);
                end
                default: begin
                    sd = int'($urandom_range(2, 5000));
                    if (i & 4) sd = -sd;
                    si = int'(a);
                    b  = 32'(sd);
                    long_op("rdiv", 4'd3, a, b, {32'(si % sd), 32'(si / sd)}, 10);
                end
            endcase
        end

        // Reset in the 3rd busy cycle of a DIV.
        chk("pre_rst_nonzero", 64'({hi, lo} != 64'd0), 64'd1);
        d0 = done_cnt;
        @(negedge clk);
        op_valid = 1'b1; op = 4'd3; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk) reset = 1'b0;
        repeat (12) @(posedge clk); #1;
        chk("midrst_nodone", 64'(done_cnt), 64'(d0));
        chk("midrst_hilo2", {hi, lo}, 64'd0);

        // WIDTH=16, single-cycle multiply.
        @(negedge clk);
        op_valid16 = 1'b1; op16 = 4'd1; src_a16 = 16'h8000; src_b16 = 16'd2;
        #1 chk("w16_stall", 64'(stall16), 64'd1);
        @(posedge clk); #1;
        op_valid16 = 1'b0; op16 = 4'd0;
        chk("w16_busy", 64'(busy16), 64'd1);
        @(posedge clk); #1;
        chk("w16_idle", 64'(busy16), 64'd0);
        chk("w16_done", 64'(done16), 64'd1);
        chk("w16_hilo", 64'({hi16, lo16}), 64'hFFFF0000);
        @(posedge clk); #1;
        chk("w16_donepulse", 64'(done16), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
